// File: rtl/npu_pkg.sv
// Shared NPU types and default constants.
package npu_pkg;

  localparam int K_H_DEF = 3;
  localparam int K_W_DEF = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    LOAD  = 3'd2,
    RUN   = 3'd3,
    DONE  = 3'd4
  } wreg_state_t;

  // Counter width for a 0..n-1 range, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/weight_reg_ctrl.sv
// Weight register controller: clears the circular weight register, loads
// K_W columns from the stream, then rotates it K_W*num_pass times.
// Optional stall counter enabled by defining WREG_CTRL_PERF_EN.
module weight_reg_ctrl
  import npu_pkg::*;
#(
  parameter int K_H    = K_H_DEF,
  parameter int K_W    = K_W_DEF,
  parameter int PASS_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [PASS_W-1:0] num_pass,
  input  logic              abort,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [8*K_H-1:0]  w_data,
  input  logic              step_en,
  output logic              reg_load_en,
  output logic              reg_shift,
  output logic              reg_clear,
  output logic [8*K_H-1:0]  reg_in_data,
  output logic              busy,
  output logic              done,
  output logic [15:0]       perf_stall
);

  localparam int          CW   = cnt_w(K_W);
  localparam logic [CW-1:0] LAST = CW'(K_W - 1);

  wreg_state_t       state_q, state_d;
  logic [CW-1:0]     col_q, col_d;
  logic [CW-1:0]     sh_q, sh_d;
  logic [PASS_W-1:0] pass_q, pass_d;
  logic [PASS_W-1:0] npass_q, npass_d;
  logic [PASS_W-1:0] pass_inc;

  logic ready_c, load_c, shift_c, clear_c, done_c;

  assign reg_in_data = w_data;
  assign pass_inc    = pass_q + PASS_W'(1);

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      col_q   <= '0;
      sh_q    <= '0;
      pass_q  <= '0;
      npass_q <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      sh_q    <= sh_d;
      pass_q  <= pass_d;
      npass_q <= npass_d;
    end
  end

  // Next-state, counter updates and register-control strobes.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    sh_d    = sh_q;
    pass_d  = pass_q;
    npass_d = npass_q;
    ready_c = 1'b0;
    load_c  = 1'b0;
    shift_c = 1'b0;
    clear_c = 1'b0;
    done_c  = 1'b0;
    if (state_q != IDLE && abort) begin
      // Abort wins over everything: wipe the register, drop the job.
      clear_c = 1'b1;
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            npass_d = num_pass;
            state_d = CLEAR;
          end
        end
        CLEAR: begin
          clear_c = 1'b1;
          col_d   = '0;
          sh_d    = '0;
          pass_d  = '0;
          state_d = LOAD;
        end
        LOAD: begin
          ready_c = 1'b1;
          load_c  = w_valid;
          if (w_valid) begin
            if (col_q == LAST) begin
              col_d   = '0;
              state_d = (npass_q == '0) ? DONE : RUN;
            end else begin
              col_d = col_q + CW'(1);
            end
          end
        end
        RUN: begin
          shift_c = step_en;
          if (step_en) begin
            if (sh_q == LAST) begin
              sh_d   = '0;
              pass_d = pass_inc;
              if (pass_inc == npass_q) state_d = DONE;
            end else begin
              sh_d = sh_q + CW'(1);
            end
          end
        end
        DONE: begin
          done_c  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs are held low while reset is asserted so a reset mid-job never
  // pulses reg_clear or leaks a stale strobe.
  assign w_ready     = ready_c & rst_n;
  assign reg_load_en = load_c  & rst_n;
  assign reg_shift   = shift_c & rst_n;
  assign reg_clear   = clear_c & rst_n;
  assign done        = done_c  & rst_n;
  assign busy        = (state_q != IDLE) & rst_n;

`ifdef WREG_CTRL_PERF_EN
  logic [15:0] perf_q, perf_d;
  logic        stall_c;

  // Saturating stall counter, zeroed when a new job enters CLEAR.
  always_comb begin
    stall_c = (state_q == LOAD && !w_valid) || (state_q == RUN && !step_en);
    perf_d  = perf_q;
    if (state_q == IDLE && start) perf_d = '0;
    else if (stall_c && perf_q != 16'hFFFF) perf_d = perf_q + 16'd1;
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) perf_q <= '0;
    else        perf_q <= perf_d;
  end

  assign perf_stall = perf_q;
`else
  assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_weight_reg_ctrl.sv
// Directed bench for weight_reg_ctrl (K_H=K_W=3, PASS_W=8).
module tb_weight_reg_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, w_valid, step_en;
  logic [7:0]  num_pass;
  logic [23:0] w_data;
  logic        w_ready, reg_load_en, reg_shift, reg_clear, busy, done;
  logic [23:0] reg_in_data;
  logic [15:0] perf_stall;

  int total = 0;
  int bad   = 0;

  // running strobe counts, sampled on the falling edge
  int c_clr = 0, c_ld = 0, c_sh = 0, c_dn = 0, c_bz = 0, c_ov = 0;
  int b_clr, b_ld, b_sh, b_dn, b_bz, b_ov;

`ifdef WREG_CTRL_PERF_EN
  localparam int PERF_ON = 1;
`else
  localparam int PERF_ON = 0;
`endif

  always #5 clk = ~clk;

  weight_reg_ctrl #(.K_H(3), .K_W(3), .PASS_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_pass(num_pass), .abort(abort),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .step_en(step_en),
    .reg_load_en(reg_load_en), .reg_shift(reg_shift), .reg_clear(reg_clear),
    .reg_in_data(reg_in_data), .busy(busy), .done(done), .perf_stall(perf_stall)
  );

  always @(negedge clk) begin
    c_clr <= c_clr + int'(reg_clear);
    c_ld  <= c_ld  + int'(reg_load_en);
    c_sh  <= c_sh  + int'(reg_shift);
    c_dn  <= c_dn  + int'(done);
    c_bz  <= c_bz  + int'(busy);
    c_ov  <= c_ov  + int'(reg_load_en & reg_shift);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
    end
  endtask

  task automatic snap();
    #2;
    b_clr = c_clr; b_ld = c_ld; b_sh = c_sh; b_dn = c_dn; b_bz = c_bz; b_ov = c_ov;
  endtask

  task automatic chk_job(input string tag, input int clr, input int ld, input int sh,
                         input int dn, input int bz);
    chk({tag, ".clr"},  c_clr - b_clr, clr);
    chk({tag, ".ld"},   c_ld  - b_ld,  ld);
    chk({tag, ".sh"},   c_sh  - b_sh,  sh);
    chk({tag, ".done"}, c_dn  - b_dn,  dn);
    chk({tag, ".busy"}, c_bz  - b_bz,  bz);
    chk({tag, ".ovl"},  c_ov  - b_ov,  0);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".ld"},    reg_load_en, 0);
    chk({tag, ".sh"},    reg_shift,   0);
    chk({tag, ".clr"},   reg_clear,   0);
    chk({tag, ".rdy"},   w_ready,     0);
    chk({tag, ".busy"},  busy,        0);
    chk({tag, ".done"},  done,        0);
  endtask

  // Pulse start for one cycle (called just after a rising edge).
  task automatic kick(input logic [7:0] np);
    num_pass = np;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
  endtask

  // Wait (bounded) until a shift is seen on a falling edge.
  task automatic wait_shift(input string tag);
    int n = 0;
    @(negedge clk);
    while (!reg_shift && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".found"}, reg_shift, 1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; w_valid = 1'b0; step_en = 1'b0;
    num_pass = 8'd0; w_data = 24'hA1B2C3;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_quiet("rst_in");
    chk("rst_in.perf", perf_stall, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_quiet("rst_out");
    chk("pass_thru", reg_in_data, 24'hA1B2C3);
    @(posedge clk); #1;

    // nominal job: 2 passes, stream and datapath always ready
    w_valid = 1'b1; step_en = 1'b1;
    snap();
    kick(8'd2);
    repeat (20) @(posedge clk);
    #1;
    chk_job("nominal", 1, 3, 6, 1, 11);
    chk("nominal.perf", perf_stall, 0);

    // gappy stream: w_valid 1,0,1,0,1 while in LOAD
    w_valid = 1'b0;
    snap();
    kick(8'd1);
    @(posedge clk); #1;        // now in LOAD
    for (int i = 0; i < 5; i++) begin
      w_valid = (i % 2 == 0);
      @(negedge clk);
      chk($sformatf("gap.coin%0d", i), reg_load_en, (i % 2 == 0) ? 1 : 0);
      @(posedge clk); #1;
    end
    w_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk_job("gap", 1, 3, 3, 1, 10);
    chk("gap.perf", perf_stall, PERF_ON ? 2 : 0);

    // zero passes: load then straight to DONE
    w_valid = 1'b1;
    snap();
    kick(8'd0);
    repeat (15) @(posedge clk);
    #1;
    chk_job("np0", 1, 3, 0, 1, 5);

    // abort on the second shift
    snap();
    kick(8'd2);
    wait_shift("abt");
    @(posedge clk); #1;
    abort = 1'b1;
    @(negedge clk);
    chk("abt.clr",  reg_clear, 1);
    chk("abt.sh",   reg_shift, 0);
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abt.idle", busy, 0);
    repeat (10) @(posedge clk);
    #1;
    chk_job("abt", 2, 3, 1, 0, 6);

    // abort while idle does nothing
    abort = 1'b1;
    @(negedge clk);
    chk("abt_idle.clr", reg_clear, 0);
    @(posedge clk); #1;
    abort = 1'b0;

    // start pulsed in the middle of RUN is ignored
    snap();
    kick(8'd2);
    wait_shift("ign");
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk_job("ign", 1, 3, 6, 1, 11);

    // reset in the middle of LOAD, then a clean job
    w_valid = 1'b0;
    kick(8'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid.rdy", w_ready, 1);
    snap();
    rst_n = 1'b0;
    #1;
    chk_quiet("mid_in");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_quiet("mid_out");
    chk("mid_out.perf", perf_stall, 0);
    @(posedge clk); #1;
    w_valid = 1'b1;
    snap();
    kick(8'd1);
    repeat (15) @(posedge clk);
    #1;
    chk_job("clean", 1, 3, 3, 1, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/weight_reg_ctrl.md
WEIGHT_REG_CTRL -- requirements
Module: weight_reg_ctrl

Interface
REQ-001 Parameter K_H, default 3, kernel height (rows in the circular weight register) SHALL be supported.
REQ-002 Parameter K_W, default 3, kernel width (columns loaded per kernel, shifts per pass) SHALL be supported.
REQ-003 Parameter PASS_W, default 8, width of pass-count field SHALL be supported.
REQ-004 Port clk  input  1  sole clock; all logic rising-edge.
REQ-005 Port rst_n  input  1  reset, synchronous, active-low.
REQ-006 Port start  input  1  one-cycle request to begin a kernel job.
REQ-007 Port num_pass  input  PASS_W  number of full K_W-shift rotations; sampled when start is accepted.
REQ-008 Port abort  input  1  terminate job immediately.
REQ-009 Port w_valid / w_ready  input / output  1 / 1  weight-column stream handshake.
REQ-010 Port w_data  input  8*K_H  one weight column, row i at bits [8i+7:8i].
REQ-011 Port step_en  input  1  datapath permits one rotation step this cycle.
REQ-012 Ports reg_load_en, reg_shift, reg_clear  output  1 each  drive the weight register's load_en, shift and clear inputs.
REQ-013 Port reg_in_data  output  8*K_H  combinational copy of w_data.
REQ-014 Ports busy / done  output  1 / 1  job active / one-cycle completion pulse.
REQ-015 Port perf_stall  output  16  stall-cycle count.

Function
REQ-016 The FSM SHALL have states IDLE, CLEAR, LOAD, RUN and DONE.
REQ-017 In IDLE, start=1 SHALL capture num_pass and move to CLEAR; start in any other state SHALL be ignored.
REQ-018 CLEAR SHALL last exactly one cycle with reg_clear=1, reset the column, shift and pass counters, then move to LOAD.
REQ-019 In LOAD, w_ready=1 and reg_load_en = w_valid & w_ready (combinational); each accepted transfer SHALL increment the column counter.
REQ-020 On the K_W-th accepted transfer, the FSM SHALL move to RUN, or to DONE if the captured num_pass is 0.
REQ-021 In RUN, reg_shift = step_en (combinational); each shift SHALL increment the shift counter modulo K_W.
REQ-022 A shift counter wrap from K_W-1 to 0 SHALL increment the pass counter.
REQ-023 When the pass counter reaches num_pass, the FSM SHALL move to DONE in the cycle after the final shift.
REQ-024 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-025 busy SHALL be 1 in every state except IDLE.
REQ-026 reg_load_en and reg_shift SHALL never be 1 in the same cycle.
REQ-027 w_ready SHALL be 0 outside LOAD.
REQ-028 abort=1 in any non-IDLE state SHALL force reg_clear=1 that cycle, suppress reg_load_en/reg_shift, go to IDLE next cycle, and produce no done pulse; abort has priority over all other events.
REQ-029 abort in IDLE SHALL have no effect.
REQ-030 Counters SHALL be sized $clog2 of their range (minimum 1 bit); the pass counter is PASS_W bits and does not wrap within a job.

Reset
REQ-031 rst_n=0 at a clock edge SHALL set the state to IDLE, all counters to 0, and perf_stall to 0.
REQ-032 During and immediately after reset, reg_load_en, reg_shift, reg_clear, w_ready, busy and done SHALL all be 0.
REQ-033 Reset mid-job SHALL discard the job without asserting reg_clear.

Configuration
REQ-034 With WREG_CTRL_PERF_EN defined, perf_stall SHALL count, saturating at 16'hFFFF, cycles in LOAD with w_valid=0 plus cycles in RUN with step_en=0; it clears on CLEAR entry.
REQ-035 Without WREG_CTRL_PERF_EN, perf_stall SHALL be tied to 0 and no counter logic is generated.

Structure
REQ-036 The state enum typedef wreg_state_t and the default K_H/K_W constants SHALL reside in the shared package npu_pkg.
REQ-037 No sub-module SHALL be used; the FSM and counters are flat in weight_reg_ctrl.

Verification
REQ-038 With K_H=K_W=3, num_pass=2, w_valid held high and step_en held high, start SHALL yield: reg_clear 1 cycle, reg_load_en 3 cycles, reg_shift 6 cycles, done 1 cycle; busy high for 11 cycles.
REQ-039 In LOAD, w_valid toggling 1,0,1,0,1 SHALL produce exactly 3 load pulses, each coinciding with w_valid=1, and perf_stall=2 (macro defined).
REQ-040 num_pass=0 SHALL produce reg_clear, 3 loads, then done, with zero shifts.
REQ-041 abort asserted on the 2nd RUN shift SHALL give reg_clear=1 and reg_shift=0 that cycle, IDLE next cycle, and no done.
REQ-042 start pulsed mid-RUN SHALL be ignored, with the shift count still equal to K_W*num_pass.
REQ-043 rst_n low mid-LOAD SHALL return all outputs to 0 next cycle, and a subsequent start SHALL run a clean job.
